// File: rtl/roi_frame_ctrl_if.sv
// Host configuration handshake and monitored pixel-stream signals for roi_frame_ctrl.
interface roi_frame_ctrl_if #(
    parameter int BIT_COORD = 32
);
    logic [BIT_COORD-1:0] cfg_xy0_i;
    logic [BIT_COORD-1:0] cfg_xy1_i;
    logic                 cfg_valid_i;
    logic                 cfg_ready_o;
    logic                 cfg_stop_i;
    logic                 s_tvalid_i;
    logic                 s_tlast_i;

    modport master (
        output cfg_xy0_i, cfg_xy1_i, cfg_valid_i, cfg_stop_i, s_tvalid_i, s_tlast_i,
        input  cfg_ready_o
    );

    modport slave (
        input  cfg_xy0_i, cfg_xy1_i, cfg_valid_i, cfg_stop_i, s_tvalid_i, s_tlast_i,
        output cfg_ready_o
    );
endinterface

// File: rtl/roi_frame_ctrl.sv
// Frame-synchronous ROI configuration controller: validates, normalises and
// holds one rectangle request, commits it at an input-frame boundary, counts
// frames and flags input frames whose length is not WIDTH*HEIGHT.
module roi_frame_ctrl #(
    parameter int WIDTH     = 800,
    parameter int HEIGHT    = 600,
    parameter int BIT_COORD = 32,
    parameter int BIT_FCNT  = 16
) (
    input  logic                 clk_i,
    input  logic                 arst_i,
    roi_frame_ctrl_if.slave      bus,
    output logic [BIT_COORD-1:0] xy_0_o,
    output logic [BIT_COORD-1:0] xy_1_o,
    output logic                 roi_en_o,
    output logic                 cfg_err_o,
    output logic                 frm_err_o,
    output logic [BIT_FCNT-1:0]  frame_cnt_o,
    output logic                 busy_o
);
    localparam int PIX     = WIDTH * HEIGHT;
    localparam int BIT_BC  = $clog2(PIX + 1);
    localparam logic [10:0]       W11      = 11'(WIDTH);
    localparam logic [9:0]        H10      = 10'(HEIGHT);
    localparam logic [BIT_BC-1:0] BC_MAX   = BIT_BC'(PIX);
    localparam logic [BIT_BC-1:0] BC_LASTV = BIT_BC'(PIX - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state_q, state_d;
    logic                in_frame_q, in_frame_d;
    logic                pend_q, pend_d;
    logic                stop_q, stop_d;
    logic [10:0]         pxa_q, pxa_d, pxb_q, pxb_d;
    logic [9:0]          pya_q, pya_d, pyb_q, pyb_d;
    logic [10:0]         axa_q, axa_d, axb_q, axb_d;
    logic [9:0]          aya_q, aya_d, ayb_q, ayb_d;
    logic [BIT_BC-1:0]   beat_cnt_q, beat_cnt_d;
    logic                ovf_q, ovf_d;
    logic [BIT_FCNT-1:0] fcnt_q, fcnt_d;
    logic                cfg_err_q, cfg_err_d;
    logic                frm_err_q, frm_err_d;

    logic [10:0] x0, x1;
    logic [9:0]  y0, y1;
    logic        req_ok, beat, last, commit;

    assign x0 = bus.cfg_xy0_i[26:16];
    assign y0 = bus.cfg_xy0_i[9:0];
    assign x1 = bus.cfg_xy1_i[26:16];
    assign y1 = bus.cfg_xy1_i[9:0];

    assign req_ok = (x0 != 11'd0) && (x0 <= W11) && (x1 != 11'd0) && (x1 <= W11) &&
                    (y0 != 10'd0) && (y0 <= H10) && (y1 != 10'd0) && (y1 <= H10);

    assign beat   = bus.s_tvalid_i;
    assign last   = bus.s_tvalid_i & bus.s_tlast_i;
    assign commit = last | (~in_frame_q & ~bus.s_tvalid_i);

    // Next-state: frame tracking, length check, boundary commit, then request accept.
    always_comb begin
        state_d    = state_q;
        in_frame_d = in_frame_q;
        pend_d     = pend_q;
        stop_d     = stop_q;
        pxa_d = pxa_q; pxb_d = pxb_q; pya_d = pya_q; pyb_d = pyb_q;
        axa_d = axa_q; axb_d = axb_q; aya_d = aya_q; ayb_d = ayb_q;
        beat_cnt_d = beat_cnt_q;
        ovf_d      = ovf_q;
        fcnt_d     = fcnt_q;
        cfg_err_d  = 1'b0;
        frm_err_d  = 1'b0;

        if (last) begin
            in_frame_d = 1'b0;
            beat_cnt_d = '0;
            ovf_d      = 1'b0;
            fcnt_d     = fcnt_q + 1'b1;
            // An overrun already flagged this frame suppresses the end-of-frame flag.
            if (!ovf_q && beat_cnt_q != BC_LASTV) frm_err_d = 1'b1;
        end else if (beat) begin
            in_frame_d = 1'b1;
            if (beat_cnt_q >= BC_MAX) begin
                if (!ovf_q) begin
                    frm_err_d = 1'b1;
                    ovf_d     = 1'b1;
                end
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end

        // Commit uses only registered pending state, so a same-cycle accept waits
        // for the following boundary; the accept below runs after the clear.
        if (commit) begin
            if (stop_q) begin
                state_d = IDLE;
                stop_d  = 1'b0;
                pend_d  = 1'b0;
            end else if (pend_q) begin
                axa_d   = pxa_q; axb_d = pxb_q;
                aya_d   = pya_q; ayb_d = pyb_q;
                pend_d  = 1'b0;
                state_d = RUN;
            end
        end

        if (bus.cfg_stop_i) stop_d = 1'b1;

        if (bus.cfg_valid_i && !pend_q) begin
            if (req_ok) begin
                pend_d = 1'b1;
                pxa_d  = (x0 < x1) ? x0 : x1;
                pxb_d  = (x0 < x1) ? x1 : x0;
                pya_d  = (y0 < y1) ? y0 : y1;
                pyb_d  = (y0 < y1) ? y1 : y0;
            end else begin
                cfg_err_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q    <= IDLE;
            in_frame_q <= 1'b0;
            pend_q     <= 1'b0;
            stop_q     <= 1'b0;
            pxa_q <= '0; pxb_q <= '0; pya_q <= '0; pyb_q <= '0;
            axa_q <= '0; axb_q <= '0; aya_q <= '0; ayb_q <= '0;
            beat_cnt_q <= '0;
            ovf_q      <= 1'b0;
            fcnt_q     <= '0;
            cfg_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_frame_q <= in_frame_d;
            pend_q     <= pend_d;
            stop_q     <= stop_d;
            pxa_q <= pxa_d; pxb_q <= pxb_d; pya_q <= pya_d; pyb_q <= pyb_d;
            axa_q <= axa_d; axb_q <= axb_d; aya_q <= aya_d; ayb_q <= ayb_d;
            beat_cnt_q <= beat_cnt_d;
            ovf_q      <= ovf_d;
            fcnt_q     <= fcnt_d;
            cfg_err_q  <= cfg_err_d;
            frm_err_q  <= frm_err_d;
        end
    end

    assign bus.cfg_ready_o = ~pend_q;
    assign busy_o          = pend_q | stop_q;
    assign roi_en_o        = (state_q == RUN);
    assign cfg_err_o       = cfg_err_q;
    assign frm_err_o       = frm_err_q;
    assign frame_cnt_o     = fcnt_q;
    assign xy_0_o = BIT_COORD'({5'd0, axa_q, 6'd0, aya_q});
    assign xy_1_o = BIT_COORD'({5'd0, axb_q, 6'd0, ayb_q});
endmodule

// File: tb/tb_roi_frame_ctrl.sv
// Directed bench for roi_frame_ctrl with an 8x4 frame.
module tb_roi_frame_ctrl;
    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic [31:0] xy_0, xy_1;
    logic        roi_en, cfg_err, frm_err, busy;
    logic [15:0] fcnt;
    int          n_checks = 0;
    int          n_errors = 0;
    int          pulses;

    roi_frame_ctrl_if #(.BIT_COORD(32)) bus ();

    roi_frame_ctrl #(
        .WIDTH(8), .HEIGHT(4), .BIT_COORD(32), .BIT_FCNT(16)
    ) dut (
        .clk_i(clk), .arst_i(arst), .bus(bus),
        .xy_0_o(xy_0), .xy_1_o(xy_1), .roi_en_o(roi_en),
        .cfg_err_o(cfg_err), .frm_err_o(frm_err),
        .frame_cnt_o(fcnt), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%08h want 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int x, input int y);
        return (32'(x) << 16) | 32'(y);
    endfunction

    // Advance one clock; outputs are looked at 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int n);
        for (int i = 1; i <= n; i++) begin
            bus.s_tvalid_i = 1'b1;
            bus.s_tlast_i  = (i == n);
            tick();
        end
        bus.s_tvalid_i = 1'b0;
        bus.s_tlast_i  = 1'b0;
    endtask

    task automatic request(input logic [31:0] a, input logic [31:0] b);
        bus.cfg_xy0_i   = a;
        bus.cfg_xy1_i   = b;
        bus.cfg_valid_i = 1'b1;
    endtask

    initial begin
        bus.cfg_xy0_i = '0; bus.cfg_xy1_i = '0; bus.cfg_valid_i = 1'b0;
        bus.cfg_stop_i = 1'b0; bus.s_tvalid_i = 1'b0; bus.s_tlast_i = 1'b0;
        repeat (3) @(negedge clk);
        arst = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_ready", 32'(bus.cfg_ready_o), 32'd1);
        chk("rst_en", 32'(roi_en), 32'd0);
        chk("rst_xy0", xy_0, 32'd0);
        chk("rst_xy1", xy_1, 32'd0);
        chk("rst_cerr", 32'(cfg_err), 32'd0);
        chk("rst_ferr", 32'(frm_err), 32'd0);
        chk("rst_fcnt", 32'(fcnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Idle request with swapped corners
        request(pk(6, 3), pk(2, 1));
        tick();
        bus.cfg_valid_i = 1'b0;
        chk("req_busy", 32'(busy), 32'd1);
        chk("req_ready", 32'(bus.cfg_ready_o), 32'd0);
        chk("req_en_pre", 32'(roi_en), 32'd0);
        tick();
        chk("cm_xy0", xy_0, 32'h0002_0001);
        chk("cm_xy1", xy_1, 32'h0006_0003);
        chk("cm_en", 32'(roi_en), 32'd1);
        chk("cm_busy", 32'(busy), 32'd0);

        // Mid-frame request, committed only at the last beat
        for (int i = 1; i <= 32; i++) begin
            bus.s_tvalid_i = 1'b1;
            bus.s_tlast_i  = (i == 32);
            if (i == 10) request(pk(1, 1), pk(4, 2));
            tick();
            bus.cfg_valid_i = 1'b0;
            if (i == 31) begin
                chk("mid_xy0_hold", xy_0, 32'h0002_0001);
                chk("mid_xy1_hold", xy_1, 32'h0006_0003);
                chk("mid_busy", 32'(busy), 32'd1);
                chk("mid_fcnt0", 32'(fcnt), 32'd0);
            end
        end
        chk("f1_xy0", xy_0, 32'h0001_0001);
        chk("f1_xy1", xy_1, 32'h0004_0002);
        chk("f1_fcnt", 32'(fcnt), 32'd1);
        chk("f1_ferr", 32'(frm_err), 32'd0);
        chk("f1_busy", 32'(busy), 32'd0);
        run_frame(32);
        chk("f2_fcnt", 32'(fcnt), 32'd2);
        chk("f2_ferr", 32'(frm_err), 32'd0);
        chk("f2_en", 32'(roi_en), 32'd1);
        chk("f2_xy1", xy_1, 32'h0004_0002);

        // Out-of-range x0 is consumed and dropped
        request(pk(9, 1), pk(2, 2));
        tick();
        bus.cfg_valid_i = 1'b0;
        chk("bad_cerr", 32'(cfg_err), 32'd1);
        chk("bad_ready", 32'(bus.cfg_ready_o), 32'd1);
        chk("bad_busy", 32'(busy), 32'd0);
        chk("bad_en", 32'(roi_en), 32'd1);
        tick();
        chk("bad_cerr_end", 32'(cfg_err), 32'd0);
        chk("bad_xy0", xy_0, 32'h0001_0001);

        // Stop and request both outstanding at the last beat: stop wins
        for (int i = 1; i <= 32; i++) begin
            bus.s_tvalid_i = 1'b1;
            bus.s_tlast_i  = (i == 32);
            bus.cfg_stop_i = (i == 5);
            if (i == 6) request(pk(3, 2), pk(5, 4));
            tick();
            bus.cfg_valid_i = 1'b0;
            bus.cfg_stop_i  = 1'b0;
            if (i == 6) chk("stp_ready_lo", 32'(bus.cfg_ready_o), 32'd0);
            if (i == 31) chk("stp_busy", 32'(busy), 32'd1);
        end
        bus.s_tvalid_i = 1'b0;
        bus.s_tlast_i  = 1'b0;
        chk("stp_en", 32'(roi_en), 32'd0);
        chk("stp_busy_clr", 32'(busy), 32'd0);
        chk("stp_ready", 32'(bus.cfg_ready_o), 32'd1);
        chk("stp_xy0_hold", xy_0, 32'h0001_0001);
        chk("stp_fcnt", 32'(fcnt), 32'd3);
        tick();
        chk("stp_en_stay", 32'(roi_en), 32'd0);

        // Short frame: tlast on beat 31
        run_frame(31);
        chk("short_ferr", 32'(frm_err), 32'd1);
        chk("short_fcnt", 32'(fcnt), 32'd4);
        tick();
        chk("short_ferr_end", 32'(frm_err), 32'd0);

        // Long frame: 33 beats, single error pulse
        pulses = 0;
        for (int i = 1; i <= 33; i++) begin
            bus.s_tvalid_i = 1'b1;
            bus.s_tlast_i  = (i == 33);
            tick();
            if (frm_err) pulses++;
            if (i == 32) chk("long_ferr_b32", 32'(frm_err), 32'd0);
            if (i == 33) chk("long_ferr_b33", 32'(frm_err), 32'd1);
        end
        bus.s_tvalid_i = 1'b0;
        bus.s_tlast_i  = 1'b0;
        tick();
        if (frm_err) pulses++;
        chk("long_pulses", 32'(pulses), 32'd1);
        chk("long_fcnt", 32'(fcnt), 32'd5);

        // Asynchronous reset mid-frame, then a clean frame
        request(pk(2, 2), pk(3, 3));
        tick();
        bus.cfg_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.s_tvalid_i = 1'b1;
            tick();
        end
        #2 arst = 1'b1;
        #1;
        chk("ar_fcnt", 32'(fcnt), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_ready", 32'(bus.cfg_ready_o), 32'd1);
        bus.s_tvalid_i = 1'b0;
        @(negedge clk);
        arst = 1'b0;
        tick();
        run_frame(32);
        chk("ar_f_fcnt", 32'(fcnt), 32'd1);
        chk("ar_f_ferr", 32'(frm_err), 32'd0);
        chk("ar_f_en", 32'(roi_en), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/roi_frame_ctrl.md
# roi_frame_ctrl

Frame-synchronous configuration controller for the ROI crop datapath. Accepts ROI rectangle requests from a host, validates and normalises them, and stores one request in a pending slot. The request is committed to the active registers only at an input-frame boundary, so a frame is never cropped with a mix of two rectangles. It drives the crop block's coordinate inputs, gates its input valid, counts frames and flags malformed input frames.

## Interface
- WIDTH, 800, frame width in pixels; x coordinates are 1-based, 1..WIDTH
- HEIGHT, 600, frame height in lines; y coordinates are 1-based, 1..HEIGHT
- BIT_COORD, 32, width of packed coordinate words
- BIT_FCNT, 16, frame counter width
- clk_i  in  1  single clock; all logic on rising edge
- arst_i  in  1  reset, asynchronous and active-high
- cfg_xy0_i  in  BIT_COORD  requested corner A, packed as x[26:16], y[9:0]; other bits ignored
- cfg_xy1_i  in  BIT_COORD  requested corner B, same packing
- cfg_valid_i  in  1  host request valid
- cfg_ready_o  out  1  pending slot empty; a request transfers on valid&ready
- cfg_stop_i  in  1  one-cycle pulse requesting a stop at the next boundary
- s_tvalid_i  in  1  input pixel-stream valid, monitored only
- s_tlast_i  in  1  input pixel-stream last beat of frame, monitored only
- xy_0_o  out  BIT_COORD  active top-left corner (min x, min y), same packing, other bits 0
- xy_1_o  out  BIT_COORD  active bottom-right corner (max x, max y)
- roi_en_o  out  1  1 while in RUN; ANDed with tvalid into the crop block
- cfg_err_o  out  1  one-cycle pulse: the accepted request was invalid and was dropped
- frm_err_o  out  1  one-cycle pulse: input frame length is not WIDTH*HEIGHT
- frame_cnt_o  out  BIT_FCNT  count of completed input frames; wraps
- busy_o  out  1  pending request or pending stop is outstanding

## Operation
- States: IDLE (roi_en_o=0) and RUN (roi_en_o=1). Reset enters IDLE.
- Beat: s_tvalid_i=1. Last beat: s_tvalid_i & s_tlast_i. in_frame register: set on a beat with s_tlast_i=0, cleared on a last beat. Reset value 0.
- Commit point: a last beat, or a cycle with in_frame=0 and s_tvalid_i=0.
- Request accept (valid & ready):
  - Valid when each of x0, x1 is in 1..WIDTH and each of y0, y1 is in 1..HEIGHT. Use 11-bit x compares and 10-bit y compares.
  - A valid request is normalised (min/max per axis) and stored in the pending slot; pend=1.
  - An invalid request is consumed, is not stored, and pulses cfg_err_o.
- cfg_ready_o = !pend. A request cannot overwrite the pending slot.
- cfg_stop_i sets stop_pend. stop_pend holds until a commit point.
- At a commit point:
  - If stop_pend: state becomes IDLE, and stop_pend and pend are cleared (stop wins). xy outputs hold their last values.
  - Else if pend: the active registers load from the pending slot, pend clears, and state becomes RUN.
  - Else: no change.
- busy_o = pend | stop_pend.
- Frame length check:
  - beat_cnt has width clog2(WIDTH*HEIGHT+1) and counts beats in the current frame.
  - On a last beat: frame_cnt_o increments, beat_cnt clears, and frm_err_o pulses if beat_cnt+1 != WIDTH*HEIGHT.
  - If a non-last beat would make the count exceed WIDTH*HEIGHT: frm_err_o pulses once per frame and beat_cnt saturates.
- Reset mid-operation: all state clears immediately, including in_frame. The next beat is treated as the start of a new frame.

## Timing
- Reset values: cfg_ready_o=1, roi_en_o=0, xy_0_o=xy_1_o=0, cfg_err_o=0, frm_err_o=0, frame_cnt_o=0, busy_o=0.
- Request accepted in cycle N → pend, busy_o=1 and cfg_ready_o=0 from N+1. For an invalid request, cfg_err_o=1 in N+1 only and cfg_ready_o stays 1.
- Commit in cycle M → new xy_*_o and roi_en_o are visible from M+1. A frame starting the cycle after its predecessor's last beat therefore uses the new rectangle.
- A request accepted in the same cycle as a commit point commits no earlier than the next commit point.
- frm_err_o and the frame_cnt_o increment appear the cycle after the offending or last beat.
- No combinational path from s_t*_i to any output. cfg_ready_o is a register output.

## Test plan
Benches use WIDTH=8, HEIGHT=4.
- Reset, then no stimulus → all outputs at their reset values; cfg_ready_o=1.
- Request x0=6,y0=3,x1=2,y1=1 while idle, with no stream → next cycle busy_o=1; following cycle xy_0_o=0x0002_0001, xy_1_o=0x0006_0003, roi_en_o=1.
- RUN with request x=1..4, y=1..2 sent mid-frame (beat 10 of 32) → active outputs unchanged until the last beat; new values visible the cycle after it. Frame 2 starting back-to-back uses the new values. frame_cnt_o goes 0→1.
- Request x0=9 → cfg_err_o pulses exactly 1 cycle, pending slot untouched, state unchanged.
- cfg_stop_i and a valid request both outstanding at a last beat → roi_en_o=0 the next cycle, busy_o=0, cfg_ready_o=1.
- Frame with tlast on beat 31 → frm_err_o one pulse. Frame of 33 beats → a single frm_err_o pulse on beat 33, and frame_cnt_o still increments at tlast.
